// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Two-requester arbiter/sequencer for a shared dual-read-port RAM.
//            Round-robin by default; fixed priority (requester 0) when the
//            RAM_ARB_FIXED_PRIO_EN macro is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int IN_W   = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr_a,
    input  logic [ADDR_W-1:0] r0_addr_b,
    input  logic [IN_W-1:0]   r0_wdata,
    output logic              r0_gnt,
    output logic              r0_done,
    output logic [DATA_W-1:0] r0_rdata_a,
    output logic [DATA_W-1:0] r0_rdata_b,

    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr_a,
    input  logic [ADDR_W-1:0] r1_addr_b,
    input  logic [IN_W-1:0]   r1_wdata,
    output logic              r1_gnt,
    output logic              r1_done,
    output logic [DATA_W-1:0] r1_rdata_a,
    output logic [DATA_W-1:0] r1_rdata_b,

    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [IN_W-1:0]   in_data,
    output logic              write_en,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_done   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_win;
    logic              r_last;
    logic              r_write_en;
    logic [ADDR_W-1:0] r_addr_a;
    logic [ADDR_W-1:0] r_addr_b;
    logic [IN_W-1:0]   r_in_data;
    logic [DATA_W-1:0] r_r0_rdata_a;
    logic [DATA_W-1:0] r_r0_rdata_b;
    logic [DATA_W-1:0] r_r1_rdata_a;
    logic [DATA_W-1:0] r_r1_rdata_b;

    logic              w_any_req;
    logic              w_both_req;
    logic              w_pick;
    logic              w_win_req;
    logic              w_grant;
    logic              w_capture;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr_a;
    logic [ADDR_W-1:0] w_sel_addr_b;
    logic [IN_W-1:0]   w_sel_wdata;

    assign w_any_req  = r0_req | r1_req;
    assign w_both_req = r0_req & r1_req;

`ifdef RAM_ARB_FIXED_PRIO_EN
    // Requester 0 always wins a tie; the pointer is kept only for visibility.
    logic w_unused_last;
    assign w_unused_last = r_last;
    assign w_pick        = w_both_req ? 1'b0 : r1_req;
`else
    assign w_pick = w_both_req ? ~r_last : r1_req;
`endif

    assign w_win_req    = r_win ? r1_req : r0_req;
    assign w_grant      = (r_state == c_st_idle) && w_any_req;
    assign w_capture    = (r_state == c_st_access) && !r_write_en;

    assign w_sel_we     = w_pick ? r1_we     : r0_we;
    assign w_sel_addr_a = w_pick ? r1_addr_a : r0_addr_a;
    assign w_sel_addr_b = w_pick ? r1_addr_b : r0_addr_b;
    assign w_sel_wdata  = w_pick ? r1_wdata  : r0_wdata;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_any_req) begin
                    w_state_nxt = c_st_access;
                end
            end
            c_st_access: begin
                w_state_nxt = c_st_done;
            end
            c_st_done: begin
                if (!w_win_req) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Output decode
    always_comb begin
        r0_gnt  = 1'b0;
        r1_gnt  = 1'b0;
        r0_done = 1'b0;
        r1_done = 1'b0;
        case (r_state)
            c_st_access: begin
                r0_gnt = ~r_win;
                r1_gnt = r_win;
            end
            c_st_done: begin
                r0_gnt  = ~r_win;
                r1_gnt  = r_win;
                r0_done = ~r_win;
                r1_done = r_win;
            end
            default: begin
                r0_gnt = 1'b0;
                r1_gnt = 1'b0;
            end
        endcase
    end

    // Arbitration bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win  <= 1'b0;
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_win  <= w_pick;
            r_last <= w_pick;
        end
    end

    // RAM-side port registers, loaded once per transaction from the winner
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_a   <= '0;
            r_addr_b   <= '0;
            r_in_data  <= '0;
            r_write_en <= 1'b0;
        end else if (w_grant) begin
            r_addr_a   <= w_sel_addr_a;
            r_addr_b   <= w_sel_addr_b;
            r_in_data  <= w_sel_wdata;
            r_write_en <= w_sel_we;
        end else if (r_state == c_st_access) begin
            r_write_en <= 1'b0;
        end
    end

    // Read-data capture at the closing edge of ACCESS, reads only
    always_ff @(posedge clk) begin
        if (rst) begin
            r_r0_rdata_a <= '0;
            r_r0_rdata_b <= '0;
            r_r1_rdata_a <= '0;
            r_r1_rdata_b <= '0;
        end else if (w_capture) begin
            if (r_win) begin
                r_r1_rdata_a <= data_a;
                r_r1_rdata_b <= data_b;
            end else begin
                r_r0_rdata_a <= data_a;
                r_r0_rdata_b <= data_b;
            end
        end
    end

    assign addr_a     = r_addr_a;
    assign addr_b     = r_addr_b;
    assign in_data    = r_in_data;
    // Reset masks the strobe so a write caught by reset at its closing edge is dropped
    assign write_en   = r_write_en & ~rst;

    assign r0_rdata_a = r_r0_rdata_a;
    assign r0_rdata_b = r_r0_rdata_b;
    assign r1_rdata_a = r_r1_rdata_a;
    assign r1_rdata_b = r_r1_rdata_b;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Purpose  : Self-checking bench for ram_port_arbiter with a RAM model, a
//            transaction-level reference model and randomized requesters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int IN_W   = 4;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic mem_init = 1'b1;
    logic chk_en   = 1'b0;
    int   total    = 0;
    int   bad      = 0;

    always #5 clk = ~clk;

    logic              ag_req [2];
    logic              ag_we  [2];
    logic [ADDR_W-1:0] ag_a   [2];
    logic [ADDR_W-1:0] ag_b   [2];
    logic [IN_W-1:0]   ag_wd  [2];

    logic              r0_req, r0_we, r0_gnt, r0_done;
    logic              r1_req, r1_we, r1_gnt, r1_done;
    logic [ADDR_W-1:0] r0_addr_a, r0_addr_b, r1_addr_a, r1_addr_b;
    logic [IN_W-1:0]   r0_wdata, r1_wdata;
    logic [DATA_W-1:0] r0_rdata_a, r0_rdata_b, r1_rdata_a, r1_rdata_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [IN_W-1:0]   in_data;
    logic              write_en;
    logic [DATA_W-1:0] data_a, data_b;

    assign r0_req = ag_req[0];  assign r1_req = ag_req[1];
    assign r0_we  = ag_we[0];   assign r1_we  = ag_we[1];
    assign r0_addr_a = ag_a[0]; assign r1_addr_a = ag_a[1];
    assign r0_addr_b = ag_b[0]; assign r1_addr_b = ag_b[1];
    assign r0_wdata  = ag_wd[0]; assign r1_wdata = ag_wd[1];

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IN_W(IN_W)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr_a(r0_addr_a), .r0_addr_b(r0_addr_b),
        .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_done(r0_done),
        .r0_rdata_a(r0_rdata_a), .r0_rdata_b(r0_rdata_b),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr_a(r1_addr_a), .r1_addr_b(r1_addr_b),
        .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_done(r1_done),
        .r1_rdata_a(r1_rdata_a), .r1_rdata_b(r1_rdata_b),
        .addr_a(addr_a), .addr_b(addr_b), .in_data(in_data), .write_en(write_en),
        .data_a(data_a), .data_b(data_b)
    );

    function automatic logic [DATA_W-1:0] init_word(input int i);
        if (i == 3) return 16'h0033;
        if (i == 7) return 16'h0077;
        return 16'(i) * 16'h1111;
    endfunction

    // Shared RAM: asynchronous reads, 4-bit write data stored zero-extended
    logic [DATA_W-1:0] ram [16];
    assign data_a = ram[addr_a];
    assign data_b = ram[addr_b];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
        end else if (write_en) begin
            ram[addr_a] <= {12'b0, in_data};
        end
    end

    // Reference model: owner of the RAM, cycles since grant, expected registers
    int                m_own;
    int                m_k;
    bit                m_last;
    logic [ADDR_W-1:0] e_addr_a, e_addr_b;
    logic [IN_W-1:0]   e_in;
    logic              e_we;
    logic [DATA_W-1:0] e_rd [2][2];
    logic [DATA_W-1:0] ref_mem [16];
    int                grant_q [$];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        end
        if (rst) begin
            m_own = -1; m_k = 0; m_last = 1'b1;
            e_addr_a = '0; e_addr_b = '0; e_in = '0; e_we = 1'b0;
            for (int i = 0; i < 2; i++) begin
                e_rd[i][0] = '0; e_rd[i][1] = '0;
            end
        end else if (m_own < 0) begin
            if (r0_req || r1_req) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                if (r0_req && r1_req) m_own = 0;
`else
                if (r0_req && r1_req) m_own = m_last ? 0 : 1;
`endif
                else m_own = r1_req ? 1 : 0;
                m_last   = (m_own == 1);
                m_k      = 0;
                e_addr_a = (m_own == 1) ? r1_addr_a : r0_addr_a;
                e_addr_b = (m_own == 1) ? r1_addr_b : r0_addr_b;
                e_in     = (m_own == 1) ? r1_wdata  : r0_wdata;
                e_we     = (m_own == 1) ? r1_we     : r0_we;
                grant_q.push_back(m_own);
            end
        end else if (m_k == 0) begin
            if (e_we) ref_mem[e_addr_a] = {12'b0, e_in};
            else begin
                e_rd[m_own][0] = ref_mem[e_addr_a];
                e_rd[m_own][1] = ref_mem[e_addr_b];
            end
            e_we = 1'b0;
            m_k  = 1;
        end else if (!((m_own == 1) ? r1_req : r0_req)) begin
            m_own = -1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("r0_gnt",     32'(r0_gnt),  32'(m_own == 0));
            chk("r1_gnt",     32'(r1_gnt),  32'(m_own == 1));
            chk("r0_done",    32'(r0_done), 32'(m_own == 0 && m_k == 1));
            chk("r1_done",    32'(r1_done), 32'(m_own == 1 && m_k == 1));
            chk("addr_a",     32'(addr_a),  32'(e_addr_a));
            chk("addr_b",     32'(addr_b),  32'(e_addr_b));
            chk("in_data",    32'(in_data), 32'(e_in));
            chk("write_en",   32'(write_en), 32'(e_we & ~rst));
            chk("r0_rdata_a", 32'(r0_rdata_a), 32'(e_rd[0][0]));
            chk("r0_rdata_b", 32'(r0_rdata_b), 32'(e_rd[0][1]));
            chk("r1_rdata_a", 32'(r1_rdata_a), 32'(e_rd[1][0]));
            chk("r1_rdata_b", 32'(r1_rdata_b), 32'(e_rd[1][1]));
            chk("gnt_excl",   32'(r0_gnt & r1_gnt), 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic done_of(input int n);
        return (n == 1) ? r1_done : r0_done;
    endfunction

    function automatic logic gnt_of(input int n);
        return (n == 1) ? r1_gnt : r0_gnt;
    endfunction

    initial begin
        int wen_cnt;
        int dcnt [2];
        int ag_st [2];
        int ag_cnt [2];
        int ag_wait [2];
        int exp_seq [4];
        int n1;

        for (int n = 0; n < 2; n++) begin
            ag_req[n] = 1'b0; ag_we[n] = 1'b0; ag_a[n] = '0; ag_b[n] = '0; ag_wd[n] = '0;
        end
        tick(1);
        chk_en = 1'b1;
        tick(1);
        mem_init = 1'b0;
        rst = 1'b0;
        chk("rst_write_en", 32'(write_en), 32'd0);
        chk("rst_r0_gnt", 32'(r0_gnt), 32'd0);
        chk("rst_addr_a", 32'(addr_a), 32'd0);

        // r0 read of addresses 3 and 7
        ag_we[0] = 1'b0; ag_a[0] = 4'd3; ag_b[0] = 4'd7; ag_req[0] = 1'b1;
        tick(1);
        chk("d1_gnt", 32'(r0_gnt), 32'd1);
        chk("d1_done_early", 32'(r0_done), 32'd0);
        tick(1);
        chk("d1_done", 32'(r0_done), 32'd1);
        chk("d1_rdata_a", 32'(r0_rdata_a), 32'h0033);
        chk("d1_rdata_b", 32'(r0_rdata_b), 32'h0077);
        ag_req[0] = 1'b0;
        tick(1);
        chk("d1_done_drop", 32'(r0_done), 32'd0);
        tick(1);

        // r1 write of 5 to address 5, then read it back
        ag_we[1] = 1'b1; ag_a[1] = 4'd5; ag_wd[1] = 4'h5; ag_req[1] = 1'b1;
        wen_cnt = 0;
        repeat (4) begin
            tick(1);
            if (write_en) wen_cnt++;
            if (r1_done) ag_req[1] = 1'b0;
        end
        chk("d2_wen_cycles", 32'(wen_cnt), 32'd1);
        ag_we[1] = 1'b0; ag_a[1] = 4'd5; ag_b[1] = 4'd2; ag_req[1] = 1'b1;
        tick(2);
        chk("d2_done", 32'(r1_done), 32'd1);
        chk("d2_rdata_a", 32'(r1_rdata_a), 32'h0005);
        chk("d2_rdata_b", 32'(r1_rdata_b), 32'h2222);
        ag_req[1] = 1'b0;
        tick(2);

        // Both requesters held, each dropping req one cycle after done
        grant_q.delete();
        dcnt[0] = 0; dcnt[1] = 0;
        ag_we[0] = 1'b0; ag_we[1] = 1'b0;
        ag_req[0] = 1'b1; ag_req[1] = 1'b1;
        repeat (30) begin
            tick(1);
            for (int n = 0; n < 2; n++) begin
                if (!ag_req[n]) ag_req[n] = 1'b1;
                else if (done_of(n)) begin
                    dcnt[n]++;
                    if (dcnt[n] == 2) begin
                        ag_req[n] = 1'b0;
                        dcnt[n] = 0;
                    end
                end
            end
        end
`ifdef RAM_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 0, 1};
`endif
        chk("d3_grant_count", 32'(grant_q.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("d3_grant_seq", 32'((i < grant_q.size()) ? grant_q[i] : -1), 32'(exp_seq[i]));
        end
`ifdef RAM_ARB_FIXED_PRIO_EN
        n1 = 0;
        foreach (grant_q[i]) if (grant_q[i] == 1) n1++;
        chk("d3_r1_starved", 32'(n1), 32'd0);
`endif
        ag_req[0] = 1'b0; ag_req[1] = 1'b0;
        tick(3);

        // r0 lingers in DONE while r1 waits
        ag_a[0] = 4'd1; ag_b[0] = 4'd2; ag_req[0] = 1'b1;
        tick(2);
        ag_a[1] = 4'd4; ag_b[1] = 4'd6; ag_req[1] = 1'b1;
        repeat (5) begin
            tick(1);
            chk("d4_r1_blocked", 32'(r1_gnt), 32'd0);
            chk("d4_r0_hold", 32'(r0_done), 32'd1);
        end
        ag_req[0] = 1'b0;
        tick(1);
        chk("d4_idle_gap", 32'(r1_gnt), 32'd0);
        tick(1);
        chk("d4_r1_gnt", 32'(r1_gnt), 32'd1);
        tick(1);
        ag_req[1] = 1'b0;
        tick(2);

        // Reset during the ACCESS cycle of a write
        ag_we[0] = 1'b1; ag_a[0] = 4'd9; ag_wd[0] = 4'hA; ag_req[0] = 1'b1;
        tick(1);
        chk("d5_wen_access", 32'(write_en), 32'd1);
        rst = 1'b1;
        tick(1);
        chk("d5_r0_gnt", 32'(r0_gnt), 32'd0);
        chk("d5_write_en", 32'(write_en), 32'd0);
        chk("d5_addr_a", 32'(addr_a), 32'd0);
        chk("d5_rdata", 32'(r0_rdata_a), 32'd0);
        rst = 1'b0; ag_req[0] = 1'b0;
        tick(1);
        ag_we[0] = 1'b0; ag_a[0] = 4'd9; ag_b[0] = 4'd3;
        ag_we[1] = 1'b0; ag_a[1] = 4'd0; ag_b[1] = 4'd0;
        ag_req[0] = 1'b1; ag_req[1] = 1'b1;
        tick(1);
        chk("d5_tie_r0", 32'(r0_gnt), 32'd1);
        tick(1);
        chk("d5_nowrite", 32'(r0_rdata_a), 32'h9999);
        chk("d5_rdata_b", 32'(r0_rdata_b), 32'h0033);
        ag_req[0] = 1'b0;
        tick(3);
        ag_req[1] = 1'b0;
        tick(2);

        // Randomized requesters with occasional resets and early drops
        for (int n = 0; n < 2; n++) begin
            ag_st[n] = 0; ag_cnt[n] = 0; ag_wait[n] = 0;
        end
        repeat (3000) begin
            tick(1);
            rst = ($urandom_range(0, 299) == 0);
            for (int n = 0; n < 2; n++) begin
                case (ag_st[n])
                    0: begin
                        if (ag_cnt[n] > 0) ag_cnt[n]--;
                        else begin
                            ag_we[n]  = ($urandom_range(0, 2) == 0);
                            ag_a[n]   = 4'($urandom_range(0, 15));
                            ag_b[n]   = 4'($urandom_range(0, 15));
                            ag_wd[n]  = 4'($urandom_range(0, 15));
                            ag_req[n] = 1'b1;
                            ag_wait[n] = 0;
                            ag_st[n] = 1;
                        end
                    end
                    1: begin
                        ag_wait[n]++;
                        if (done_of(n)) begin
                            ag_cnt[n] = $urandom_range(0, 3);
                            ag_st[n] = 2;
                        end else if (gnt_of(n) && $urandom_range(0, 7) == 0) begin
                            ag_req[n] = 1'b0;
                            ag_st[n] = 3;
                        end else if (ag_wait[n] > 100) begin
                            bad++; total++;
                            $display("FAIL agent%0d_timeout: waited %0d cycles, required at most 100", n, ag_wait[n]);
                            ag_req[n] = 1'b0;
                            ag_st[n] = 3;
                        end
                    end
                    2: begin
                        if (ag_cnt[n] > 0) ag_cnt[n]--;
                        else begin
                            ag_req[n] = 1'b0;
                            ag_st[n] = 3;
                        end
                    end
                    default: begin
                        if (!gnt_of(n) && !done_of(n)) begin
                            ag_cnt[n] = $urandom_range(0, 3);
                            ag_st[n] = 0;
                        end
                    end
                endcase
            end
        end
        rst = 1'b0;
        ag_req[0] = 1'b0; ag_req[1] = 1'b0;
        tick(4);
        for (int i = 0; i < 16; i++) chk("mem_contents", 32'(ram[i]), 32'(ref_mem[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
